// File: rtl/sprite_move_scheduler_if.sv
// Sprite move request/ack bundle and registered position outputs.
// master drives requests and frame events; slave is the scheduler.
interface sprite_move_scheduler_if;
  logic       frame_tick;
  logic [1:0] req;
  logic [1:0] dir0;
  logic [1:0] dir1;
  logic [1:0] ack;
  logic       grant_id;
  logic       busy;
  logic [9:0] posX;
  logic [9:0] posY;

  modport master (
    output frame_tick, req, dir0, dir1,
    input  ack, grant_id, busy, posX, posY
  );

  modport slave (
    input  frame_tick, req, dir0, dir1,
    output ack, grant_id, busy, posX, posY
  );
endinterface

// File: rtl/sprite_move_scheduler.sv
// Round-robin sprite mover: one bounded step per frame event.
// Define SPRITE_WRAP_EN to wrap at the screen edges instead of clamping.
module sprite_move_scheduler #(
  parameter int H_MAX    = 640,
  parameter int V_MAX    = 480,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int STEP     = 8,
  parameter int X_INIT   = 304,
  parameter int Y_INIT   = 224
) (
  input logic clk,
  input logic reset,
  sprite_move_scheduler_if.slave bus
);

  localparam int X_LIM = H_MAX - SPRITE_W;
  localparam int Y_LIM = V_MAX - SPRITE_H;

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] XLIM_S = 11'(X_LIM);
  localparam logic signed [10:0] YLIM_S = 11'(Y_LIM);

`ifdef SPRITE_WRAP_EN
  localparam logic [9:0] X_UNDER = 10'(X_LIM);
  localparam logic [9:0] X_OVER  = 10'd0;
  localparam logic [9:0] Y_UNDER = 10'(Y_LIM);
  localparam logic [9:0] Y_OVER  = 10'd0;
`else
  localparam logic [9:0] X_UNDER = 10'd0;
  localparam logic [9:0] X_OVER  = 10'(X_LIM);
  localparam logic [9:0] Y_UNDER = 10'd0;
  localparam logic [9:0] Y_OVER  = 10'(Y_LIM);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_APPLY,
    S_ACK
  } state_e;

  state_e     state_q, state_d;
  logic       tick_q;
  logic       ptr_q, ptr_d;
  logic       win_q, win_d;
  logic       gid_q, gid_d;
  logic [1:0] dir_q, dir_d;
  logic [9:0] posx_q, posx_d;
  logic [9:0] posy_q, posy_d;

  logic       tick_evt;
  logic       any_req;
  logic       win_c;
  logic [9:0] nx, ny;

  logic signed [10:0] x_dec, x_inc;
  logic signed [10:0] y_dec, y_inc;

  assign tick_evt = bus.frame_tick & ~tick_q;
  assign any_req  = |bus.req;

  // A lone requester wins outright; a tie goes to the pointer.
  always_comb begin
    win_c = ptr_q;
    unique case (bus.req)
      2'b01:   win_c = 1'b0;
      2'b10:   win_c = 1'b1;
      default: win_c = ptr_q;
    endcase
  end

  assign x_dec = $signed({1'b0, posx_q}) - STEP_S;
  assign x_inc = $signed({1'b0, posx_q}) + STEP_S;
  assign y_dec = $signed({1'b0, posy_q}) - STEP_S;
  assign y_inc = $signed({1'b0, posy_q}) + STEP_S;

  always_comb begin
    nx = posx_q;
    ny = posy_q;
    unique case (dir_q)
      2'b00: ny = (y_dec < 0) ? Y_UNDER : y_dec[9:0];
      2'b01: ny = (y_inc > YLIM_S) ? Y_OVER : y_inc[9:0];
      2'b10: nx = (x_dec < 0) ? X_UNDER : x_dec[9:0];
      2'b11: nx = (x_inc > XLIM_S) ? X_OVER : x_inc[9:0];
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gid_d   = gid_q;
    dir_d   = dir_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    unique case (state_q)
      S_IDLE: begin
        if (tick_evt && any_req) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (any_req) begin
          win_d   = win_c;
          gid_d   = win_c;
          dir_d   = win_c ? bus.dir1 : bus.dir0;
          state_d = S_APPLY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        posx_d  = nx;
        posy_d  = ny;
        state_d = S_ACK;
      end
      S_ACK: begin
        ptr_d   = ~win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tick history resets high so a tick held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tick_q  <= 1'b1;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      gid_q   <= 1'b0;
      dir_q   <= 2'b00;
      posx_q  <= 10'(X_INIT);
      posy_q  <= 10'(Y_INIT);
    end else begin
      state_q <= state_d;
      tick_q  <= bus.frame_tick;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gid_q   <= gid_d;
      dir_q   <= dir_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
    end
  end

  always_comb begin
    bus.ack = 2'b00;
    if (state_q == S_ACK) bus.ack = win_q ? 2'b10 : 2'b01;
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.grant_id = (state_q == S_GRANT && any_req) ? win_c : gid_q;
  assign bus.posX     = posx_q;
  assign bus.posY     = posy_q;

endmodule
